bus_input_sampler: RTL



---
 rtl/bus_input_sampler_pkg.sv | 18 +
 rtl/bus_input_line_filter.sv | 72 +++++++
 rtl/bus_input_sampler.sv | 57 +++++
 3 files changed

// File: rtl/bus_input_sampler_pkg.sv
// Shared constants and helpers for the MITM bus input sampler.
// Idle level is shared with the protocol sniffer blocks.
package bus_input_sampler_pkg;

  localparam logic BUS_IDLE_LEVEL = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int cnt_width(input int fc);
    return clog2(fc) + 1;
  endfunction

endpackage

// File: rtl/bus_input_line_filter.sv
// One bus line: synchroniser chain, glitch filter and edge pulses.
// Glitch strobe port exists only with BUS_INPUT_GLITCH_COUNT_EN.
module bus_input_line_filter
  import bus_input_sampler_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 3,
  parameter logic RESET_BIT     = BUS_IDLE_LEVEL
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
`ifdef BUS_INPUT_GLITCH_COUNT_EN
  ,
  output logic glitch
`endif
);

  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_d;
  logic                   lvl_d;
  logic                   rise_d;
  logic                   fall_d;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

`ifdef BUS_INPUT_GLITCH_COUNT_EN
  // Level fell back to f with a partial count pending.
  assign glitch = (s == level) && (cnt != '0);
`endif

  always_comb begin
    cnt_d  = '0;
    lvl_d  = level;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != level) begin
      if (cnt == CMAX) begin
        lvl_d  = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync  <= {SYNC_STAGES{RESET_BIT}};
      level <= RESET_BIT;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], din};
      level <= lvl_d;
      cnt   <= cnt_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

// File: rtl/bus_input_sampler.sv
// Receive front end for the MITM bus: sync, deglitch, edge pulses.
// Optional glitch_count output under BUS_INPUT_GLITCH_COUNT_EN.
module bus_input_sampler
  import bus_input_sampler_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{BUS_IDLE_LEVEL}}
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] in_line,
  output logic [WIDTH-1:0] out_line,
  output logic [WIDTH-1:0] rise_edge,
  output logic [WIDTH-1:0] fall_edge
`ifdef BUS_INPUT_GLITCH_COUNT_EN
  ,
  output logic [15:0]      glitch_count
`endif
);

`ifdef BUS_INPUT_GLITCH_COUNT_EN
  logic [WIDTH-1:0] glitch_bits;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    bus_input_line_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_BIT    (RESET_VALUE[i])
    ) u_line (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .din    (in_line[i]),
      .level  (out_line[i]),
      .rise   (rise_edge[i]),
      .fall   (fall_edge[i])
`ifdef BUS_INPUT_GLITCH_COUNT_EN
      ,
      .glitch (glitch_bits[i])
`endif
    );
  end

`ifdef BUS_INPUT_GLITCH_COUNT_EN
  // One count per cycle regardless of how many bits rejected.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      glitch_count <= '0;
    end else if (|glitch_bits && glitch_count != 16'hFFFF) begin
      glitch_count <= glitch_count + 16'd1;
    end
  end
`endif

endmodule
